// File: rtl/toy_pack.sv
// ============================================================================
//  Module      : toy_pack
//  Description : Shared types and sizing constants for the toy branch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package toy_pack;

    localparam int BTQ_DEPTH  = 8;
    localparam int BTQ_WR_NUM = 2;

    // One predicted fetch block handed from bp2 to the fetch filter.
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  tag;
    } bpu_pkg;

endpackage : toy_pack

`default_nettype wire

// File: rtl/toy_bpu_btq_lane_cmp.sv
// ============================================================================
//  Module      : toy_bpu_btq_lane_cmp
//  Description : Prefix count of eligible bp2 lanes: per-lane write offset
//                and the total number of entries written this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toy_bpu_btq_lane_cmp #(
    parameter int WR_NUM = 2,
    parameter int OFF_W  = 3,
    parameter int CNT_W  = 4
) (
    input  logic [WR_NUM-1:0]            lane_vld,
    input  logic [WR_NUM-1:0]            lane_chgflw,
    output logic [WR_NUM-1:0]            lane_elig,
    output logic [WR_NUM-1:0][OFF_W-1:0] lane_off,
    output logic [CNT_W-1:0]             lane_nwr
);

    logic [CNT_W-1:0] w_acc;

    assign lane_elig = lane_vld & ~lane_chgflw;

    // Exclusive prefix sum: each lane's offset is the count of eligible lanes below it.
    always_comb begin
        w_acc    = '0;
        lane_off = '0;
        for (int i = 0; i < WR_NUM; i++) begin
            lane_off[i] = w_acc[OFF_W-1:0];
            w_acc       = w_acc + CNT_W'(lane_elig[i]);
        end
        lane_nwr = w_acc;
    end

endmodule : toy_bpu_btq_lane_cmp

`default_nettype wire

// File: rtl/toy_bpu_btq.sv
// ============================================================================
//  Module      : toy_bpu_btq
//  Description : Branch target queue between bp2 and the fetch filter; takes
//                up to WR_NUM compacted lanes per cycle, drains one per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toy_bpu_btq
    import toy_pack::*;
#(
    parameter int DEPTH  = BTQ_DEPTH,
    parameter int WR_NUM = BTQ_WR_NUM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WR_NUM-1:0]        bpdec_bp2_vld,
    input  logic [WR_NUM-1:0]        bpdec_bp2_chgflw,
    input  bpu_pkg [WR_NUM-1:0]      bpdec_bp2_pld,
    output logic                     bpdec_bp2_rdy,
    input  logic                     filter_rdy,
    output logic                     filter_vld,
    output bpu_pkg                   filter_pld,
    output logic [$clog2(DEPTH):0]   btq_cnt,
    input  logic                     fe_ctrl_flush
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [CNT_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_wr_ptr;
    logic [CNT_W-1:0]            r_cnt;
    bpu_pkg                      r_mem [DEPTH];

    logic [WR_NUM-1:0]           w_elig;
    logic [WR_NUM-1:0][PW-1:0]   w_off;
    logic [CNT_W-1:0]            w_lane_nwr;
    logic [CNT_W-1:0]            w_nwr;
    logic [CNT_W-1:0]            w_free;
    logic [PW-1:0]               w_wr_idx [WR_NUM];
    logic                        w_enq;
    logic                        w_deq;

    toy_bpu_btq_lane_cmp #(
        .WR_NUM (WR_NUM),
        .OFF_W  (PW),
        .CNT_W  (CNT_W)
    ) u_lane_cmp (
        .lane_vld    (bpdec_bp2_vld),
        .lane_chgflw (bpdec_bp2_chgflw),
        .lane_elig   (w_elig),
        .lane_off    (w_off),
        .lane_nwr    (w_lane_nwr)
    );

    // Ready looks only at registered occupancy so the producer sees no comb path.
    assign w_free        = CNT_W'(DEPTH) - r_cnt;
    assign bpdec_bp2_rdy = (w_free >= CNT_W'(WR_NUM));

    assign w_enq      = bpdec_bp2_rdy & ~fe_ctrl_flush;
    assign w_nwr      = w_enq ? w_lane_nwr : '0;
    assign filter_vld = (r_cnt != '0) & ~fe_ctrl_flush;
    assign w_deq      = filter_vld & filter_rdy;

    assign btq_cnt    = r_cnt;
    assign filter_pld = r_mem[r_rd_ptr[PW-1:0]];

    generate
        for (genvar g = 0; g < WR_NUM; g++) begin : g_wr_idx
            assign w_wr_idx[g] = r_wr_ptr[PW-1:0] + w_off[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || fe_ctrl_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_nwr;
            r_rd_ptr <= r_rd_ptr + CNT_W'(w_deq);
            r_cnt    <= r_cnt + w_nwr - CNT_W'(w_deq);
        end
    end

    // Payload store carries no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_NUM; i++) begin
            if (!rst && w_enq && w_elig[i]) begin
                r_mem[w_wr_idx[i]] <= bpdec_bp2_pld[i];
            end
        end
    end

endmodule : toy_bpu_btq

`default_nettype wire

// File: tb/tb_toy_bpu_btq.sv
// ============================================================================
//  Module      : tb_toy_bpu_btq
//  Description : Directed self-checking bench for toy_bpu_btq (DEPTH=8, WR_NUM=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toy_bpu_btq;
    import toy_pack::*;

    logic         clk;
    logic         rst;
    logic [1:0]   vld;
    logic [1:0]   chg;
    bpu_pkg [1:0] pld;
    logic         bp2_rdy;
    logic         frdy;
    logic         fvld;
    bpu_pkg       fpld;
    logic [3:0]   cnt;
    logic         flush;

    int total = 0;
    int bad   = 0;

    toy_bpu_btq #(
        .DEPTH  (8),
        .WR_NUM (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bpdec_bp2_vld    (vld),
        .bpdec_bp2_chgflw (chg),
        .bpdec_bp2_pld    (pld),
        .bpdec_bp2_rdy    (bp2_rdy),
        .filter_rdy       (frdy),
        .filter_vld       (fvld),
        .filter_pld       (fpld),
        .btq_cnt          (cnt),
        .fe_ctrl_flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bpu_pkg mk(input int n);
        bpu_pkg p;
        p.pc  = 32'h1000 + 32'(n) * 4;
        p.tag = 8'(n);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] c, input int a, input int b);
        vld    = v;
        chg    = c;
        pld[0] = mk(a);
        pld[1] = mk(b);
    endtask

    task automatic head(input string tag, input int n);
        chk(tag, 64'(fpld), 64'(mk(n)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; frdy = 1'b0;
        drive(2'b00, 2'b00, 0, 0);
        step();
        rst = 1'b0;
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_fvld", 64'(fvld), 64'd0);
        chk("rst_rdy", 64'(bp2_rdy), 64'd1);

        // Basic two-lane enqueue, then drain in order
        drive(2'b11, 2'b00, 1, 2);
        step();
        drive(2'b00, 2'b00, 0, 0);
        chk("basic_cnt2", 64'(cnt), 64'd2);
        chk("basic_fvld", 64'(fvld), 64'd1);
        head("basic_headA", 1);
        frdy = 1'b1;
        step();
        chk("basic_cnt1", 64'(cnt), 64'd1);
        head("basic_headB", 2);
        step();
        chk("basic_cnt0", 64'(cnt), 64'd0);
        chk("basic_empty", 64'(fvld), 64'd0);
        frdy = 1'b0;

        // Change-of-flow filtering
        drive(2'b11, 2'b01, 3, 4);
        step();
        drive(2'b00, 2'b00, 0, 0);
        chk("filt_cnt1", 64'(cnt), 64'd1);
        head("filt_headB", 4);
        drive(2'b10, 2'b10, 5, 6);
        step();
        drive(2'b00, 2'b00, 0, 0);
        chk("filt_none", 64'(cnt), 64'd1);
        frdy = 1'b1;
        step();
        frdy = 1'b0;
        chk("filt_drain", 64'(cnt), 64'd0);

        // Fill to full under backpressure
        drive(2'b11, 2'b00, 5, 6);   step();
        chk("full_g1", 64'(cnt), 64'd2);
        drive(2'b11, 2'b00, 7, 8);   step();
        chk("full_g2", 64'(cnt), 64'd4);
        drive(2'b11, 2'b00, 9, 10);  step();
        chk("full_g3_cnt", 64'(cnt), 64'd6);
        chk("full_g3_rdy", 64'(bp2_rdy), 64'd1);
        drive(2'b11, 2'b00, 11, 12); step();
        chk("full_g4_cnt", 64'(cnt), 64'd8);
        chk("full_g4_rdy", 64'(bp2_rdy), 64'd0);
        drive(2'b11, 2'b00, 13, 14); step();
        chk("full_hold_cnt", 64'(cnt), 64'd8);
        head("full_head5", 5);
        frdy = 1'b1;
        step();
        chk("full_deq1_cnt", 64'(cnt), 64'd7);
        chk("full_deq1_rdy", 64'(bp2_rdy), 64'd0);
        head("full_head6", 6);
        step();
        chk("full_deq2_cnt", 64'(cnt), 64'd6);
        chk("full_deq2_rdy", 64'(bp2_rdy), 64'd1);
        frdy = 1'b0;
        step();
        drive(2'b00, 2'b00, 0, 0);
        chk("full_g5_cnt", 64'(cnt), 64'd8);
        head("full_head7", 7);

        // Flush from full clears everything
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush1_cnt", 64'(cnt), 64'd0);

        // Walk wr_ptr to 7, then straddle the wrap with a simultaneous dequeue
        drive(2'b11, 2'b00, 20, 21); step();
        drive(2'b11, 2'b00, 22, 23); step();
        drive(2'b11, 2'b00, 24, 25); step();
        chk("wrap_pre_cnt", 64'(cnt), 64'd6);
        drive(2'b01, 2'b00, 26, 99); frdy = 1'b1; step();
        chk("wrap_sim_cnt", 64'(cnt), 64'd6);
        head("wrap_head21", 21);
        drive(2'b11, 2'b00, 27, 28); step();
        drive(2'b00, 2'b00, 0, 0);
        chk("wrap_strad_cnt", 64'(cnt), 64'd7);
        for (int n = 22; n <= 28; n++) begin
            head("wrap_order", n);
            step();
        end
        chk("wrap_empty", 64'(fvld), 64'd0);
        frdy = 1'b0;

        // Flush with a concurrent write and ready consumer
        drive(2'b11, 2'b00, 30, 31); step();
        chk("flush2_pre", 64'(cnt), 64'd2);
        drive(2'b11, 2'b00, 32, 33); flush = 1'b1; frdy = 1'b1;
        #1;
        chk("flush2_fvld", 64'(fvld), 64'd0);
        step();
        flush = 1'b0; frdy = 1'b0;
        drive(2'b00, 2'b00, 0, 0);
        chk("flush2_cnt", 64'(cnt), 64'd0);
        chk("flush2_empty", 64'(fvld), 64'd0);
        drive(2'b01, 2'b00, 34, 0); step();
        drive(2'b00, 2'b00, 0, 0);
        chk("flush2_post_cnt", 64'(cnt), 64'd1);
        head("flush2_head34", 34);

        // Mid-stream reset behaves like a flush
        drive(2'b11, 2'b00, 35, 36); step();
        chk("rst2_pre", 64'(cnt), 64'd3);
        drive(2'b11, 2'b00, 38, 39); frdy = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; frdy = 1'b0;
        drive(2'b00, 2'b00, 0, 0);
        chk("rst2_cnt", 64'(cnt), 64'd0);
        chk("rst2_fvld", 64'(fvld), 64'd0);
        chk("rst2_rdy", 64'(bp2_rdy), 64'd1);
        drive(2'b10, 2'b00, 0, 37); step();
        drive(2'b00, 2'b00, 0, 0);
        chk("rst2_post_cnt", 64'(cnt), 64'd1);
        head("rst2_head37", 37);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_toy_bpu_btq

`default_nettype wire
